// File: rtl/AMITypes.sv
// Shared AMI memory-port types.
// Request/response bundles used by every AMI memory endpoint.
package AMITypes;

   localparam int AMI_ADDR_WIDTH = 64;
   localparam int AMI_DATA_WIDTH = 512;

   typedef struct packed {
      logic                      valid;
      logic                      isWrite;
      logic [AMI_ADDR_WIDTH-1:0] addr;
      logic [AMI_DATA_WIDTH-1:0] data;
   } MemReq;

   typedef struct packed {
      logic                      valid;
      logic [AMI_DATA_WIDTH-1:0] data;
   } MemResp;

endpackage

// File: rtl/ami_bram_responder_if.sv
// AMI memory port bundle between a requester (master)
// and a memory responder (slave).
interface ami_bram_responder_if;
   import AMITypes::*;

   MemReq  mem_req_in;
   logic   mem_req_grant_out;
   MemResp mem_resp_out;
   logic   mem_resp_grant_in;

   modport master (
      output mem_req_in,
      output mem_resp_grant_in,
      input  mem_req_grant_out,
      input  mem_resp_out
   );

   modport slave (
      input  mem_req_in,
      input  mem_resp_grant_in,
      output mem_req_grant_out,
      output mem_resp_out
   );

endinterface

// File: rtl/ami_resp_fifo.sv
// Response queue: power-of-two FIFO with wrap-bit pointers.
// Push and pop may coincide when full or empty.
module ami_resp_fifo #(
   parameter int WIDTH     = 512,
   parameter int LOG_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int DEPTH = 1 << LOG_DEPTH;

   logic [WIDTH-1:0]   mem [DEPTH];
   logic [LOG_DEPTH:0] wr_ptr;
   logic [LOG_DEPTH:0] rd_ptr;
   logic               do_push;
   logic               do_pop;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[LOG_DEPTH] != rd_ptr[LOG_DEPTH]) &&
                  (wr_ptr[LOG_DEPTH-1:0] == rd_ptr[LOG_DEPTH-1:0]);

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr[LOG_DEPTH-1:0]];

   // storage write; a full push+pop reuses the slot being popped
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr[LOG_DEPTH-1:0]] <= push_data;
   end

   // pointer update
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + (LOG_DEPTH+1)'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + (LOG_DEPTH+1)'(1);
      end
   end

endmodule

// File: rtl/ami_bram_responder.sv
// Block-RAM AMI memory responder: in-order reads through a
// fixed-latency pipeline into a credit-protected response queue.
module ami_bram_responder
   import AMITypes::*;
#(
   parameter int DATA_WIDTH   = 512,
   parameter int LOG_SIZE     = 10,
   parameter int LOG_Q_SIZE   = 4,
   parameter int READ_LATENCY = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   ami_bram_responder_if.slave  bus
);

   localparam int DEPTH = 1 << LOG_SIZE;
   localparam logic [LOG_Q_SIZE:0] Q = (LOG_Q_SIZE+1)'(1 << LOG_Q_SIZE);

   logic [DATA_WIDTH-1:0]   mem [DEPTH];
   logic [LOG_SIZE-1:0]     widx;
   logic                    grant;
   logic                    accept;
   logic                    rd_accept;
   logic                    wr_accept;
   logic [READ_LATENCY-1:0] p_valid;
   logic [DATA_WIDTH-1:0]   p_data [READ_LATENCY];
   logic [LOG_Q_SIZE:0]     outstanding;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic                    resp_valid;
   logic                    pop;
   logic [DATA_WIDTH-1:0]   head;
   MemResp                  resp;
   logic                    unused;

   assign widx      = bus.mem_req_in.addr[LOG_SIZE+5:6];
   assign grant     = !rst && (outstanding < Q);
   assign accept    = bus.mem_req_in.valid && grant;
   assign wr_accept = accept && bus.mem_req_in.isWrite;
   assign rd_accept = accept && !bus.mem_req_in.isWrite;

   assign bus.mem_req_grant_out = grant;

   assign resp_valid = !rst && !fifo_empty;
   assign pop        = resp_valid && bus.mem_resp_grant_in;

   // array write and read data pipeline; contents survive reset
   always_ff @(posedge clk) begin
      if (wr_accept)
         mem[widx] <= bus.mem_req_in.data[DATA_WIDTH-1:0];
      p_data[0] <= mem[widx];
      for (int i = 1; i < READ_LATENCY; i++)
         p_data[i] <= p_data[i-1];
   end

   // read valid pipeline, flushed by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         p_valid <= '0;
      end else begin
         p_valid[0] <= rd_accept;
         for (int i = 1; i < READ_LATENCY; i++)
            p_valid[i] <= p_valid[i-1];
      end
   end

   // credits: reads in the pipeline plus entries in the queue
   always_ff @(posedge clk) begin
      if (rst)
         outstanding <= '0;
      else if (rd_accept && !pop)
         outstanding <= outstanding + (LOG_Q_SIZE+1)'(1);
      else if (!rd_accept && pop)
         outstanding <= outstanding - (LOG_Q_SIZE+1)'(1);
   end

   ami_resp_fifo #(
      .WIDTH     (DATA_WIDTH),
      .LOG_DEPTH (LOG_Q_SIZE)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (p_valid[READ_LATENCY-1]),
      .push_data (p_data[READ_LATENCY-1]),
      .pop       (pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (head)
   );

   assign resp.valid = resp_valid;
   assign resp.data  = resp_valid ? AMI_DATA_WIDTH'(head) : '0;
   assign bus.mem_resp_out = resp;

   assign unused = ^{bus.mem_req_in.addr[5:0],
                     bus.mem_req_in.addr[AMI_ADDR_WIDTH-1:LOG_SIZE+6],
                     fifo_full};

endmodule

// File: tb/tb_ami_bram_responder.sv
// Directed bench for ami_bram_responder: vector table for the
// write/read stream, hand sequences for credits, wrap, RAW, reset.
module tb_ami_bram_responder;
   import AMITypes::*;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   ami_bram_responder_if bus();

   ami_bram_responder dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      logic        v;
      logic        w;
      logic [63:0] a;
      logic [31:0] d;
      logic        g;
      logic        eg;
      logic        ev;
      logic [31:0] ed;
   } vec_t;

   vec_t tbl [20];
   int n_cmp = 0;
   int n_bad = 0;
   logic [511:0] got [$];

   task automatic chk(input string name, input logic [511:0] act,
                      input logic [511:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic w, input logic [63:0] a,
                        input logic [31:0] d, input logic g);
      @(posedge clk);
      #1;
      bus.mem_req_in.valid   = v;
      bus.mem_req_in.isWrite = w;
      bus.mem_req_in.addr    = a;
      bus.mem_req_in.data    = 512'(d);
      bus.mem_resp_grant_in  = g;
      #1;
   endtask

   task automatic rd_chk(input string name, input logic [63:0] a,
                         input logic [31:0] e);
      int lat;
      bit hit;
      drive(1'b1, 1'b0, a, 32'h0, 1'b1);
      chk({name, "_grant"}, 512'(bus.mem_req_grant_out), 512'd1);
      lat = 0;
      hit = 0;
      for (int i = 0; i < 10 && !hit; i++) begin
         drive(1'b0, 1'b0, 64'h0, 32'h0, 1'b1);
         lat++;
         if (bus.mem_resp_out.valid) begin
            hit = 1;
            chk(name, bus.mem_resp_out.data, 512'(e));
            chk({name, "_lat"}, 512'(lat), 512'd3);
         end
      end
      if (!hit) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: no response, expected %0h", name, e);
      end
   endtask

   initial begin
      int acc;
      int pops;
      int stale;

      rst = 1'b1;
      bus.mem_req_in        = '0;
      bus.mem_resp_grant_in = 1'b0;

      // reset state
      drive(1'b0, 1'b0, 64'h0, 32'h0, 1'b0);
      drive(1'b1, 1'b1, 64'h0, 32'h0, 1'b1);
      chk("rst_grant", 512'(bus.mem_req_grant_out), 512'd0);
      chk("rst_valid", 512'(bus.mem_resp_out.valid), 512'd0);
      chk("rst_data", bus.mem_resp_out.data, 512'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.mem_req_in = '0;
      #1;
      chk("post_rst_grant", 512'(bus.mem_req_grant_out), 512'd1);

      // write 8 words then read them back in order
      for (int i = 0; i < 8; i++) begin
         tbl[i]    = '{1'b1, 1'b1, 64'(i * 64), 32'hDEAD0000 + 32'(i),
                       1'b1, 1'b1, 1'b0, 32'h0};
         tbl[8+i]  = '{1'b1, 1'b0, 64'(i * 64), 32'h0,
                       1'b1, 1'b1, 1'b0, 32'h0};
      end
      for (int i = 0; i < 4; i++)
         tbl[16+i] = '{1'b0, 1'b0, 64'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0};
      for (int i = 0; i < 8; i++) begin
         tbl[11+i].ev = 1'b1;
         tbl[11+i].ed = 32'hDEAD0000 + 32'(i);
      end
      for (int i = 0; i < 20; i++) begin
         drive(tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].g);
         chk($sformatf("vec%0d_grant", i),
             512'(bus.mem_req_grant_out), 512'(tbl[i].eg));
         chk($sformatf("vec%0d_valid", i),
             512'(bus.mem_resp_out.valid), 512'(tbl[i].ev));
         if (tbl[i].ev)
            chk($sformatf("vec%0d_data", i),
                bus.mem_resp_out.data, 512'(tbl[i].ed));
      end

      // credit limit with the consumer stalled
      acc = 0;
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 1'b0, 64'h0, 32'h0, 1'b0);
         if (bus.mem_req_grant_out)
            acc++;
      end
      chk("credit_accepts", 512'(acc), 512'd16);
      chk("credit_grant_low", 512'(bus.mem_req_grant_out), 512'd0);
      chk("credit_outstanding", 512'(dut.outstanding), 512'd16);
      drive(1'b1, 1'b0, 64'h0, 32'h0, 1'b1);
      chk("pop_cycle_grant", 512'(bus.mem_req_grant_out), 512'd0);
      chk("pop_cycle_valid", 512'(bus.mem_resp_out.valid), 512'd1);
      chk("pop_cycle_data", bus.mem_resp_out.data, 512'h DEAD0000);
      drive(1'b1, 1'b0, 64'h0, 32'h0, 1'b0);
      chk("grant_after_pop", 512'(bus.mem_req_grant_out), 512'd1);
      drive(1'b0, 1'b0, 64'h0, 32'h0, 1'b0);
      chk("refill_outstanding", 512'(dut.outstanding), 512'd16);
      pops = 0;
      for (int i = 0; i < 30; i++) begin
         drive(1'b0, 1'b0, 64'h0, 32'h0, 1'b1);
         if (bus.mem_resp_out.valid)
            pops++;
      end
      chk("drain_pops", 512'(pops), 512'd16);
      chk("drain_outstanding", 512'(dut.outstanding), 512'd0);

      // address wrap and ignored low bits
      drive(1'b1, 1'b1, 64'h0, 32'hBEEF0001, 1'b1);
      rd_chk("wrap", 64'(1024 * 64), 32'hBEEF0001);
      drive(1'b1, 1'b1, 64'(64 + 5), 32'h55AA, 1'b1);
      rd_chk("low_bits", 64'd64, 32'h55AA);

      // read-after-write ordering
      got.delete();
      drive(1'b1, 1'b1, 64'd128, 32'hA, 1'b1);
      drive(1'b1, 1'b0, 64'd128, 32'h0, 1'b1);
      if (bus.mem_resp_out.valid) got.push_back(bus.mem_resp_out.data);
      drive(1'b1, 1'b1, 64'd128, 32'hB, 1'b1);
      if (bus.mem_resp_out.valid) got.push_back(bus.mem_resp_out.data);
      drive(1'b1, 1'b0, 64'd128, 32'h0, 1'b1);
      if (bus.mem_resp_out.valid) got.push_back(bus.mem_resp_out.data);
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 1'b0, 64'h0, 32'h0, 1'b1);
         if (bus.mem_resp_out.valid) got.push_back(bus.mem_resp_out.data);
      end
      chk("raw_count", 512'(got.size()), 512'd2);
      chk("raw_first", (got.size() > 0) ? got[0] : 512'hX, 512'hA);
      chk("raw_second", (got.size() > 1) ? got[1] : 512'hX, 512'hB);

      // reset in the middle of queued reads
      drive(1'b1, 1'b1, 64'd256, 32'h1234, 1'b1);
      for (int i = 0; i < 5; i++)
         drive(1'b1, 1'b0, 64'd256, 32'h0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      bus.mem_req_in.valid   = 1'b1;
      bus.mem_req_in.isWrite = 1'b0;
      #1;
      chk("mid_rst_valid", 512'(bus.mem_resp_out.valid), 512'd0);
      chk("mid_rst_grant", 512'(bus.mem_req_grant_out), 512'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.mem_req_in = '0;
      #1;
      chk("after_rst_outstanding", 512'(dut.outstanding), 512'd0);
      stale = 0;
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, 1'b0, 64'h0, 32'h0, 1'b1);
         if (bus.mem_resp_out.valid)
            stale++;
      end
      chk("stale_resps", 512'(stale), 512'd0);
      rd_chk("keep_data", 64'd256, 32'h1234);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
